// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration stream loader.
// Covers the parser state encoding, the frame markers and the frame-field widths.
package cfg_loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned TILE_W      = 8;
    localparam int unsigned LEN_W       = 8;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [TILE_W-1:0] END_TILE_DEF  = 8'hFF;

    typedef enum logic [2:0] {
        S_HUNT,
        S_TILE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/cfg_onehot_dec.sv
// Tile index to one-hot select decoder.
// Any index at or beyond NB_TILES decodes to all zeros.
module cfg_onehot_dec #(
    parameter int unsigned NB_TILES = 16,
    parameter int unsigned IDX_W    = 8
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [NB_TILES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NB_TILES; i++) begin
            if (32'(idx) == i) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/cfg_stream_loader.sv
// Framed byte-stream parser producing one-cycle tile write strobes.
// Frames are checksummed; completion and error status are sticky until reset.
module cfg_stream_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned       NB_TILES  = 16,
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [TILE_W-1:0] END_TILE  = END_TILE_DEF
) (
    input  logic                   conf,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NB_TILES-1:0]    select_tile,
    output logic [ADDR_W-1:0]      address_tile,
    output logic [DATA_W-1:0]      data_tile,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    state_t                state;
    logic [TILE_W-1:0]     tile;
    logic [DATA_W-1:0]     addr_h;
    logic [DATA_W-1:0]     csum;
    logic [LEN_W-1:0]      remaining;
    logic [ADDR_W-1:0]     addr;
    logic [NB_TILES-1:0]   tile_sel;
    logic [2*DATA_W-1:0]   addr_full;
    logic                  accept;
    logic                  tile_bad;

    assign accept    = in_valid && in_ready;
    assign addr_full = {addr_h, in_data};
    assign tile_bad  = (32'(tile) >= NB_TILES) && (tile != END_TILE);

    // END_TILE and invalid indices both decode to zero, so their data bytes strobe nothing.
    cfg_onehot_dec #(
        .NB_TILES (NB_TILES),
        .IDX_W    (TILE_W)
    ) u_dec (
        .idx    (tile),
        .onehot (tile_sel)
    );

    always_ff @(posedge conf or negedge reset) begin
        if (!reset) begin
            state        <= S_HUNT;
            in_ready     <= 1'b1;
            select_tile  <= '0;
            address_tile <= '0;
            data_tile    <= '0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            frame_count  <= '0;
            tile         <= '0;
            addr_h       <= '0;
            addr         <= '0;
            remaining    <= '0;
            csum         <= '0;
        end else begin
            select_tile <= '0;
            if (accept) begin
                case (state)
                    S_HUNT: begin
                        if (in_data == SYNC_BYTE) state <= S_TILE;
                    end
                    S_TILE: begin
                        tile  <= in_data;
                        csum  <= in_data;
                        state <= S_ADDR_H;
                    end
                    S_ADDR_H: begin
                        addr_h <= in_data;
                        csum   <= csum ^ in_data;
                        state  <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        addr  <= addr_full[ADDR_W-1:0];
                        csum  <= csum ^ in_data;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        remaining <= in_data;
                        csum      <= csum ^ in_data;
                        state     <= (in_data == '0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        select_tile  <= tile_sel;
                        address_tile <= addr;
                        data_tile    <= in_data;
                        addr         <= addr + ADDR_W'(1);
                        remaining    <= remaining - LEN_W'(1);
                        csum         <= csum ^ in_data;
                        if (remaining == LEN_W'(1)) state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (tile_bad || in_data != csum) begin
                            cfg_error <= 1'b1;
                            state     <= S_HUNT;
                        end else begin
                            if (frame_count != '1) frame_count <= frame_count + FRAME_CNT_W'(1);
                            if (tile == END_TILE) begin
                                state    <= S_DONE;
                                in_ready <= 1'b0;
                                cfg_done <= 1'b1;
                            end else begin
                                state <= S_HUNT;
                            end
                        end
                    end
                    S_DONE: begin
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: drives framed byte streams and checks
// logged tile write strobes and status outputs against hand-computed values.
module tb_cfg_stream_loader;

    logic        conf;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] select_tile;
    logic [9:0]  address_tile;
    logic [7:0]  data_tile;
    logic        cfg_done;
    logic        cfg_error;
    logic [15:0] frame_count;

    typedef struct {
        logic [15:0] sel;
        logic [9:0]  addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        log_q[$];
    logic [7:0] stim[$];
    int         cycle;
    int         checks;
    int         errors;

    cfg_stream_loader dut (
        .conf         (conf),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .select_tile  (select_tile),
        .address_tile (address_tile),
        .data_tile    (data_tile),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .frame_count  (frame_count)
    );

    initial conf = 1'b0;
    always #5 conf = ~conf;

    initial cycle = 0;
    always @(posedge conf) cycle <= cycle + 1;

    always @(negedge conf) begin
        if (select_tile != '0) log_q.push_back('{select_tile, address_tile, data_tile, cycle});
    end

    task automatic play();
        for (int i = 0; i < stim.size(); i++) begin
            @(negedge conf);
            in_data  = stim[i];
            in_valid = 1'b1;
        end
        @(negedge conf);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge conf);
    endtask

    task automatic do_reset();
        @(negedge conf);
        reset = 1'b0;
        repeat (2) @(negedge conf);
        reset = 1'b1;
        @(negedge conf);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge conf);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (select_tile !== 16'h0) begin errors++; $display("FAIL reset_select got %h want 0000", select_tile); end
        checks++; if (cfg_done !== 1'b0 || cfg_error !== 1'b0) begin errors++; $display("FAIL reset_status got done=%b err=%b want 0/0", cfg_done, cfg_error); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0000", frame_count); end
        reset = 1'b1;
        @(negedge conf);
    endtask

    task automatic test_good_frame();
        log_q.delete();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h23};
        play();
        checks++;
        if (log_q.size() !== 2) begin
            errors++; $display("FAIL good_nwrites got %0d want 2", log_q.size());
        end else begin
            checks++; if (log_q[0].sel !== 16'h0004 || log_q[0].addr !== 10'h010 || log_q[0].data !== 8'h11) begin
                errors++; $display("FAIL good_w0 got %h/%h/%h want 0004/010/11", log_q[0].sel, log_q[0].addr, log_q[0].data); end
            checks++; if (log_q[1].sel !== 16'h0004 || log_q[1].addr !== 10'h011 || log_q[1].data !== 8'h22) begin
                errors++; $display("FAIL good_w1 got %h/%h/%h want 0004/011/22", log_q[1].sel, log_q[1].addr, log_q[1].data); end
            checks++; if (log_q[1].cyc !== log_q[0].cyc + 1) begin
                errors++; $display("FAIL good_back_to_back got gap %0d want 1", log_q[1].cyc - log_q[0].cyc); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL good_count got %0d want 1", frame_count); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL good_error got %b want 0", cfg_error); end
    endtask

    task automatic test_addr_wrap();
        log_q.delete();
        stim = '{8'hA5, 8'h00, 8'h03, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEF};
        play();
        checks++;
        if (log_q.size() !== 2) begin
            errors++; $display("FAIL wrap_nwrites got %0d want 2", log_q.size());
        end else begin
            checks++; if (log_q[0].sel !== 16'h0001 || log_q[0].addr !== 10'h3FF || log_q[0].data !== 8'hAA) begin
                errors++; $display("FAIL wrap_w0 got %h/%h/%h want 0001/3ff/aa", log_q[0].sel, log_q[0].addr, log_q[0].data); end
            checks++; if (log_q[1].sel !== 16'h0001 || log_q[1].addr !== 10'h000 || log_q[1].data !== 8'hBB) begin
                errors++; $display("FAIL wrap_w1 got %h/%h/%h want 0001/000/bb", log_q[1].sel, log_q[1].addr, log_q[1].data); end
        end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", frame_count); end
    endtask

    task automatic test_bad_csum();
        log_q.delete();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h24};
        play();
        checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL badcsum_nwrites got %0d want 2", log_q.size()); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL badcsum_error got %b want 1", cfg_error); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL badcsum_count got %0d want 2", frame_count); end
    endtask

    task automatic test_garbage();
        log_q.delete();
        stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h23};
        play();
        checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL garbage_nwrites got %0d want 2", log_q.size()); end
        else begin
            checks++; if (log_q[0].addr !== 10'h010 || log_q[0].data !== 8'h11) begin
                errors++; $display("FAIL garbage_w0 got %h/%h want 010/11", log_q[0].addr, log_q[0].data); end
        end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL garbage_count got %0d want 3", frame_count); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL garbage_sticky_error got %b want 1", cfg_error); end
    endtask

    task automatic test_bad_tile();
        do_reset();
        log_q.delete();
        stim = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h01, 8'h77, 8'h56};
        play();
        checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL badtile_nwrites got %0d want 0", log_q.size()); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL badtile_error got %b want 1", cfg_error); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL badtile_count got %0d want 0", frame_count); end
    endtask

    task automatic test_end_frame();
        log_q.delete();
        stim = '{8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        play();
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL end_done got %b want 1", cfg_done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL end_in_ready got %b want 0", in_ready); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL end_count got %0d want 1", frame_count); end
        stim = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h01, 8'h11, 8'h03};
        play();
        checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL done_ignores_input got %0d writes want 0", log_q.size()); end
        @(negedge conf);
        reset = 1'b0;
        #1;
        checks++; if (cfg_done !== 1'b0 || cfg_error !== 1'b0 || frame_count !== 16'd0) begin
            errors++; $display("FAIL end_reset_clear got done=%b err=%b cnt=%0d want 0/0/0", cfg_done, cfg_error, frame_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL end_reset_ready got %b want 1", in_ready); end
        repeat (2) @(negedge conf);
        reset = 1'b1;
        @(negedge conf);
    endtask

    task automatic test_reset_mid_data();
        log_q.delete();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h04, 8'h11, 8'h22};
        for (int i = 0; i < stim.size(); i++) begin
            @(negedge conf);
            in_data  = stim[i];
            in_valid = 1'b1;
        end
        @(negedge conf);
        in_data = 8'h33;
        #1 reset = 1'b0;
        repeat (3) @(negedge conf);
        checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL middata_nwrites got %0d want 2", log_q.size()); end
        checks++; if (select_tile !== 16'h0) begin errors++; $display("FAIL middata_select got %h want 0000", select_tile); end
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge conf);
        checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL middata_after_release got %0d want 2", log_q.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_good_frame();
        test_addr_wrap();
        test_bad_csum();
        test_garbage();
        test_bad_tile();
        test_end_frame();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
